dataflow_stall_monitor: RTL and testbench

Parametrised, synthesizable successor to the simulation-only dataflow deadlock monitor. It watches per-process idle/block flags and per-AXI-stream block flags from a dataflow kernel. A stall must persist, with no change in which flags are set, for a programmable number of cycles before it is declared. Each declared stall is classified as an internal deadlock (sticky, needs `clear`) or an external AXI-stream stall (self-clearing), and the blocked-signal vectors are captured for debug readout. It sits beside the kernel top-level, fed by the same flag buses the simulation monitor uses.

---
 rtl/dataflow_mon_pkg.sv | 26 ++
 rtl/dataflow_stall_monitor_lowest_set_idx.sv | 22 ++
 rtl/dataflow_stall_monitor.sv | 177 +++++++++++++++++
 tb/tb_dataflow_stall_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_mon_pkg.sv
// Shared types and helpers for the dataflow stall monitor.
//   mon_state_t : monitor FSM state with fixed encodings (visible on the state port)
//   *_DEF       : default parameter values for the monitor top
//   sat_inc     : saturating increment for counters up to 32 bits wide
package dataflow_mon_pkg;

    localparam int unsigned N_AXIS_DEF    = 12;
    localparam int unsigned N_INST_DEF    = 16;
    localparam int unsigned TIMEOUT_W_DEF = 16;
    localparam int unsigned CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        WATCH    = 2'd0,
        SUSPECT  = 2'd1,
        EXT      = 2'd2,
        DEADLOCK = 2'd3
    } mon_state_t;

    // Increment value, holding at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : (value + 32'd1);
    endfunction

endpackage

// File: rtl/dataflow_stall_monitor_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of vec, 0 when vec is all zeros.
//   vec   : input vector
//   idx_c : combinational index of the lowest set bit
module lowest_set_idx #(
    parameter  int unsigned W  = 16,
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx_c
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_c = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx_c = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dataflow_stall_monitor.sv
// Dataflow stall monitor. Watches per-instance idle/block flags and per-stream
// block flags; a stall whose flag pattern stays unchanged for timeout_cycles
// cycles is declared either an internal deadlock (sticky) or an external
// stream stall (released when the stall goes away).
//   kernel_monitor_clock : clock
//   kernel_monitor_reset : asynchronous active-high reset
//   axis_block_sigs      : per-stream blocked-on-TDATA flags
//   inst_idle_sigs       : per-instance idle flags
//   inst_block_sigs      : per-instance blocked flags
//   timeout_cycles       : persistence threshold, 0 behaves as 1
//   clear                : synchronous clear of sticky state and counters
//   block                : internal deadlock declared (registered, sticky)
//   ext_stall            : external stream stall declared (registered)
//   state                : current FSM state encoding
//   snap_inst/snap_axis  : block flags captured at declaration
//   first_inst_idx       : lowest set index of snap_inst
//   deadlock_cnt/ext_cnt : saturating declaration counters
module dataflow_stall_monitor
    import dataflow_mon_pkg::*;
#(
    parameter  int unsigned N_AXIS    = N_AXIS_DEF,
    parameter  int unsigned N_INST    = N_INST_DEF,
    parameter  int unsigned TIMEOUT_W = TIMEOUT_W_DEF,
    parameter  int unsigned CNT_W     = CNT_W_DEF,
    localparam int unsigned IDX_W     = (N_INST > 1) ? $clog2(N_INST) : 1
) (
    input  logic                 kernel_monitor_clock,
    input  logic                 kernel_monitor_reset,
    input  logic [N_AXIS-1:0]    axis_block_sigs,
    input  logic [N_INST-1:0]    inst_idle_sigs,
    input  logic [N_INST-1:0]    inst_block_sigs,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 clear,
    output logic                 block,
    output logic                 ext_stall,
    output logic [1:0]           state,
    output logic [N_INST-1:0]    snap_inst,
    output logic [N_AXIS-1:0]    snap_axis,
    output logic [IDX_W-1:0]     first_inst_idx,
    output logic [CNT_W-1:0]     deadlock_cnt,
    output logic [CNT_W-1:0]     ext_cnt
);

    localparam int unsigned REF_W = N_INST + N_AXIS;

    mon_state_t           state_q;
    mon_state_t           state_n;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_n;
    logic [REF_W-1:0]     ref_q;
    logic [REF_W-1:0]     ref_n;
    logic [N_INST-1:0]    snap_inst_n;
    logic [N_AXIS-1:0]    snap_axis_n;
    logic [IDX_W-1:0]     first_inst_idx_n;
    logic [CNT_W-1:0]     deadlock_cnt_n;
    logic [CNT_W-1:0]     ext_cnt_n;

    logic                 stalled_c;
    logic                 changed_c;
    logic [REF_W-1:0]     flags_c;
    logic [TIMEOUT_W-1:0] thresh_c;
    logic [IDX_W-1:0]     enc_idx_c;

    // Every instance idle or blocked, but not all idle (all idle = kernel done).
    assign stalled_c = (&(inst_idle_sigs | inst_block_sigs)) & ~(&inst_idle_sigs);
    assign flags_c   = {inst_block_sigs, axis_block_sigs};
    assign changed_c = (flags_c != ref_q);
    assign thresh_c  = (timeout_cycles == '0) ? TIMEOUT_W'(1) : timeout_cycles;

    assign state = state_q;

    // Lowest blocked instance in the current flags, captured on declaration.
    lowest_set_idx #(
        .W(N_INST)
    ) u_lowest_set_idx (
        .vec   (inst_block_sigs),
        .idx_c (enc_idx_c)
    );

    // Next-state and datapath next values; clear overrides everything.
    always_comb begin
        state_n          = state_q;
        cnt_n            = cnt_q;
        ref_n            = ref_q;
        snap_inst_n      = snap_inst;
        snap_axis_n      = snap_axis;
        first_inst_idx_n = first_inst_idx;
        deadlock_cnt_n   = deadlock_cnt;
        ext_cnt_n        = ext_cnt;

        case (state_q)
            WATCH: begin
                if (stalled_c) begin
                    state_n = SUSPECT;
                    cnt_n   = TIMEOUT_W'(1);
                    ref_n   = flags_c;
                end
            end
            SUSPECT: begin
                if (!stalled_c) begin
                    state_n = WATCH;
                    cnt_n   = '0;
                end else if (changed_c) begin
                    // A change in the flag pattern is progress: restart measuring.
                    cnt_n = TIMEOUT_W'(1);
                    ref_n = flags_c;
                end else if (cnt_q >= thresh_c) begin
                    cnt_n            = '0;
                    snap_inst_n      = inst_block_sigs;
                    snap_axis_n      = axis_block_sigs;
                    first_inst_idx_n = enc_idx_c;
                    if (|axis_block_sigs) begin
                        state_n   = EXT;
                        ext_cnt_n = CNT_W'(sat_inc(32'(ext_cnt), CNT_W));
                    end else begin
                        state_n        = DEADLOCK;
                        deadlock_cnt_n = CNT_W'(sat_inc(32'(deadlock_cnt), CNT_W));
                    end
                end else begin
                    cnt_n = TIMEOUT_W'(sat_inc(32'(cnt_q), TIMEOUT_W));
                end
            end
            EXT: begin
                // Classification is fixed once declared; only release matters.
                if (!stalled_c) begin
                    state_n = WATCH;
                    cnt_n   = '0;
                end
            end
            DEADLOCK: begin
                state_n = DEADLOCK;
            end
            default: begin
                state_n = WATCH;
            end
        endcase

        if (clear) begin
            state_n          = WATCH;
            cnt_n            = '0;
            ref_n            = '0;
            snap_inst_n      = '0;
            snap_axis_n      = '0;
            first_inst_idx_n = '0;
            deadlock_cnt_n   = '0;
            ext_cnt_n        = '0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
        if (kernel_monitor_reset) begin
            state_q        <= WATCH;
            cnt_q          <= '0;
            ref_q          <= '0;
            snap_inst      <= '0;
            snap_axis      <= '0;
            first_inst_idx <= '0;
            deadlock_cnt   <= '0;
            ext_cnt        <= '0;
            block          <= 1'b0;
            ext_stall      <= 1'b0;
        end else begin
            state_q        <= state_n;
            cnt_q          <= cnt_n;
            ref_q          <= ref_n;
            snap_inst      <= snap_inst_n;
            snap_axis      <= snap_axis_n;
            first_inst_idx <= first_inst_idx_n;
            deadlock_cnt   <= deadlock_cnt_n;
            ext_cnt        <= ext_cnt_n;
            block          <= (state_n == DEADLOCK);
            ext_stall      <= (state_n == EXT);
        end
    end

endmodule

// File: tb/tb_dataflow_stall_monitor.sv
// Self-checking bench for dataflow_stall_monitor: directed stimulus, a
// run-length behavioural model compared every cycle, plus literal checks.
module tb_dataflow_stall_monitor;

    logic        clk;
    logic        rst;
    logic [11:0] axis_block_sigs;
    logic [15:0] inst_idle_sigs;
    logic [15:0] inst_block_sigs;
    logic [15:0] timeout_cycles;
    logic        clear;
    logic        block;
    logic        ext_stall;
    logic [1:0]  state;
    logic [15:0] snap_inst;
    logic [11:0] snap_axis;
    logic [3:0]  first_inst_idx;
    logic [7:0]  deadlock_cnt;
    logic [7:0]  ext_cnt;

    int checks = 0;
    int errors = 0;

    dataflow_stall_monitor dut (
        .kernel_monitor_clock (clk),
        .kernel_monitor_reset (rst),
        .axis_block_sigs      (axis_block_sigs),
        .inst_idle_sigs       (inst_idle_sigs),
        .inst_block_sigs      (inst_block_sigs),
        .timeout_cycles       (timeout_cycles),
        .clear                (clear),
        .block                (block),
        .ext_stall            (ext_stall),
        .state                (state),
        .snap_inst            (snap_inst),
        .snap_axis            (snap_axis),
        .first_inst_idx       (first_inst_idx),
        .deadlock_cnt         (deadlock_cnt),
        .ext_cnt              (ext_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counts how many consecutive stalled samples carried the same flags.
    int          m_mode;   // 0 watching, 2 external stall, 3 deadlock
    int          m_run;
    logic [27:0] m_prev;
    logic [15:0] m_snap_inst;
    logic [11:0] m_snap_axis;
    int          m_dl;
    int          m_ext;

    function automatic bit model_stalled(input logic [15:0] idl, input logic [15:0] blk);
        bit all_idle = 1'b1;
        bit all_busy_free = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!idl[i]) all_idle = 1'b0;
            if (!idl[i] && !blk[i]) all_busy_free = 1'b0;
        end
        return all_busy_free && !all_idle;
    endfunction

    function automatic int lowest_bit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_zero();
        m_mode = 0; m_run = 0; m_prev = '0;
        m_snap_inst = '0; m_snap_axis = '0; m_dl = 0; m_ext = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            model_zero();
        end else if (m_mode == 0) begin
            if (!model_stalled(inst_idle_sigs, inst_block_sigs)) begin
                m_run = 0;
            end else begin
                if (m_run > 0 && {inst_block_sigs, axis_block_sigs} == m_prev) m_run++;
                else m_run = 1;
                m_prev = {inst_block_sigs, axis_block_sigs};
                // Stall is declared on the sample that follows T earlier matching samples.
                if (m_run - 1 >= ((timeout_cycles == 0) ? 1 : int'(timeout_cycles))) begin
                    m_snap_inst = inst_block_sigs;
                    m_snap_axis = axis_block_sigs;
                    m_run = 0;
                    if (axis_block_sigs != 0) begin
                        m_mode = 2;
                        if (m_ext < 255) m_ext++;
                    end else begin
                        m_mode = 3;
                        if (m_dl < 255) m_dl++;
                    end
                end
            end
        end else if (m_mode == 2) begin
            if (!model_stalled(inst_idle_sigs, inst_block_sigs)) begin
                m_mode = 0;
                m_run = 0;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("m_state", 32'(state), (m_mode == 0) ? ((m_run > 0) ? 32'd1 : 32'd0) : 32'(m_mode));
        chk("m_block", 32'(block), 32'(m_mode == 3));
        chk("m_ext_stall", 32'(ext_stall), 32'(m_mode == 2));
        chk("m_snap_inst", 32'(snap_inst), 32'(m_snap_inst));
        chk("m_snap_axis", 32'(snap_axis), 32'(m_snap_axis));
        chk("m_first_idx", 32'(first_inst_idx), 32'(lowest_bit(m_snap_inst)));
        chk("m_deadlock_cnt", 32'(deadlock_cnt), 32'(m_dl));
        chk("m_ext_cnt", 32'(ext_cnt), 32'(m_ext));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_stall(input logic [15:0] blk, input logic [11:0] ax);
        inst_block_sigs = blk;
        inst_idle_sigs  = ~blk;
        axis_block_sigs = ax;
    endtask

    task automatic set_idle();
        inst_block_sigs = '0;
        inst_idle_sigs  = '1;
        axis_block_sigs = '0;
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        timeout_cycles = 16'd4;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_block", 32'(block), 32'd0);
        chk("reset_ext", 32'(ext_stall), 32'd0);
        chk("reset_dl_cnt", 32'(deadlock_cnt), 32'd0);
        tick(2);

        // Internal deadlock, T=4: SUSPECT after 1 edge, block after 5.
        timeout_cycles = 16'd4;
        set_stall(16'h0020, 12'h000);
        tick(1);
        chk("a_suspect", 32'(state), 32'd1);
        tick(3);
        chk("a_block_early", 32'(block), 32'd0);
        tick(1);
        chk("a_block", 32'(block), 32'd1);
        chk("a_dl_cnt", 32'(deadlock_cnt), 32'd1);
        chk("a_snap_inst", 32'(snap_inst), 32'h0020);
        chk("a_first_idx", 32'(first_inst_idx), 32'd5);
        tick(3);
        chk("a_sticky", 32'(state), 32'd3);
        // Clear while in DEADLOCK.
        clear = 1'b1;
        set_idle();
        tick(1);
        clear = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_block", 32'(block), 32'd0);
        chk("clr_dl_cnt", 32'(deadlock_cnt), 32'd0);
        chk("clr_snap", 32'(snap_inst), 32'd0);
        tick(2);

        // Pattern change two cycles in restarts the window: block after 7 edges.
        set_stall(16'h0020, 12'h000);
        tick(2);
        set_stall(16'h0060, 12'h000);
        tick(4);
        chk("b_block_early", 32'(block), 32'd0);
        tick(1);
        chk("b_block", 32'(block), 32'd1);
        chk("b_snap_inst", 32'(snap_inst), 32'h0060);
        chk("b_first_idx", 32'(first_inst_idx), 32'd5);
        clear = 1'b1;
        set_idle();
        tick(1);
        clear = 1'b0;
        tick(2);

        // External stall, T=3, then no reclassification, then release.
        timeout_cycles = 16'd3;
        set_stall(16'h0001, 12'h100);
        tick(3);
        chk("c_ext_early", 32'(ext_stall), 32'd0);
        tick(1);
        chk("c_ext", 32'(ext_stall), 32'd1);
        chk("c_ext_cnt", 32'(ext_cnt), 32'd1);
        chk("c_block", 32'(block), 32'd0);
        tick(8);
        set_stall(16'h0001, 12'h000);
        tick(3);
        chk("c_no_reclass", 32'(state), 32'd2);
        set_idle();
        tick(1);
        chk("c_release", 32'(state), 32'd0);
        chk("c_snap_axis", 32'(snap_axis), 32'h100);
        chk("c_ext_off", 32'(ext_stall), 32'd0);

        // All idle is completion, not a stall.
        tick(100);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_dl_cnt", 32'(deadlock_cnt), 32'd0);

        // Clear on the declaration edge wins.
        timeout_cycles = 16'd2;
        set_stall(16'h0004, 12'h000);
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        set_idle();
        chk("cd_state", 32'(state), 32'd0);
        chk("cd_block", 32'(block), 32'd0);
        chk("cd_dl_cnt", 32'(deadlock_cnt), 32'd0);
        tick(2);

        // T=0 behaves as T=1.
        timeout_cycles = 16'd0;
        set_stall(16'h8000, 12'h000);
        tick(1);
        chk("t0_block_early", 32'(block), 32'd0);
        tick(1);
        chk("t0_block", 32'(block), 32'd1);
        chk("t0_first_idx", 32'(first_inst_idx), 32'd15);
        clear = 1'b1;
        set_idle();
        tick(1);
        clear = 1'b0;
        tick(1);

        // Asynchronous reset mid-SUSPECT takes effect before the next edge.
        timeout_cycles = 16'd10;
        set_stall(16'h0002, 12'h000);
        tick(2);
        chk("ar_suspect", 32'(state), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_state", 32'(state), 32'd0);
        chk("ar_block", 32'(block), 32'd0);
        set_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);

        // Asynchronous reset while in DEADLOCK.
        timeout_cycles = 16'd1;
        set_stall(16'h0002, 12'h000);
        tick(2);
        chk("ard_block", 32'(block), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ard_block_off", 32'(block), 32'd0);
        chk("ard_dl_cnt", 32'(deadlock_cnt), 32'd0);
        set_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);

        // Repeated external stalls saturate ext_cnt at 255.
        timeout_cycles = 16'd1;
        for (int k = 0; k < 260; k++) begin
            set_stall(16'h0010, 12'h001);
            tick(3);
            set_idle();
            tick(1);
        end
        chk("sat_ext_cnt", 32'(ext_cnt), 32'd255);
        chk("sat_state", 32'(state), 32'd0);
        chk("sat_dl_cnt", 32'(deadlock_cnt), 32'd0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
